mem_result_checker: RTL

- Synthesizable end-of-test result checker that sits beside the unified memory in top_axi.
- After program completion, or on watchdog expiry, it walks a configurable window of memory words one at a time.
- Each word is compared against a golden source; the block reports pass/fail, the error count and the first mismatch.
- It provides the same checking as the simulation bench, but parametrised, handshaked and usable in emulation.

---
 rtl/mem_result_checker_pkg.sv | 26 ++
 rtl/mem_result_checker_if.sv | 38 +++
 rtl/mem_result_checker_chk_watchdog.sv | 36 +++
 rtl/mem_result_checker.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_result_checker_pkg.sv
// Shared types and default widths for the end-of-test memory result checker.
// The result struct is sized by these defaults; the top module's parameters default to them.
package mem_result_checker_pkg;

    localparam int unsigned ChkXlen  = 32;
    localparam int unsigned ChkAddrW = 32;
    localparam int unsigned ChkDepth = 1024;
    localparam int unsigned ChkCntW  = $clog2(ChkDepth + 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRsp,
        StDone
    } chk_state_e;

    typedef struct packed {
        logic                pass;
        logic                timeout;
        logic [ChkCntW-1:0]  err_count;
        logic [ChkAddrW-1:0] first_err_addr;
        logic [ChkXlen-1:0]  first_err_mem;
        logic [ChkXlen-1:0]  first_err_gold;
    } chk_result_t;

endpackage

// File: rtl/mem_result_checker_if.sv
// Memory read request/response and golden-source lookup bundle for the result checker.
interface mem_result_checker_if
    import mem_result_checker_pkg::*;
#(
    parameter int unsigned XLEN   = ChkXlen,
    parameter int unsigned ADDR_W = ChkAddrW,
    parameter int unsigned CNT_W  = ChkCntW
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_data;
    logic [CNT_W-1:0]  golden_idx;
    logic [XLEN-1:0]   golden_data;

    modport master (
        output req_valid,
        output req_addr,
        output golden_idx,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  golden_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  golden_idx,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output golden_data
    );

endinterface

// File: rtl/mem_result_checker_chk_watchdog.sv
// Idle watchdog: counts enabled cycles and pulses expire on the cycle the count hits the limit.
module chk_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_limit;

    assign at_limit = (cnt_q == Limit);
    assign expire_o = en_i && at_limit;

    // Holds at the limit so a lingering enable cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_result_checker.sv
// End-of-test checker: walks a memory window one word at a time against a golden source
// after program completion or watchdog expiry, reporting pass/fail and the first mismatch.
module mem_result_checker
    import mem_result_checker_pkg::*;
#(
    parameter int unsigned XLEN           = ChkXlen,
    parameter int unsigned ADDR_W         = ChkAddrW,
    parameter int unsigned DEPTH          = ChkDepth,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    debug_base,
    input  logic [CNT_W-1:0]     word_count,
    input  logic                 stop_on_first,
    mem_result_checker_if.master mem,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [CNT_W-1:0]     err_count,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic [XLEN-1:0]      first_err_mem,
    output logic [XLEN-1:0]      first_err_gold
);

    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    chk_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              stop_q, stop_d;
    chk_result_t       res_q, res_d;

    logic              wd_expire;
    logic              launch;
    logic              mismatch;
    logic [CNT_W-1:0]  n_clamped;
    logic [CNT_W-1:0]  idx_next;
    logic [ADDR_W-1:0] cur_addr;

    chk_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .en_i    (state_q == StIdle),
        .expire_o(wd_expire)
    );

    assign n_clamped = (word_count > DepthCnt) ? DepthCnt : word_count;
    assign cur_addr  = base_q + (ADDR_W'(idx_q) << 2);
    assign idx_next  = idx_q + 1'b1;
    assign mismatch  = (mem.rsp_data != mem.golden_data);

    // Start is honoured in IDLE or DONE; expiry only fires while IDLE since the watchdog is gated.
    assign launch = (start && (state_q == StIdle || state_q == StDone)) || wd_expire;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        n_d     = n_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        res_d   = res_q;

        if (launch) begin
            base_d        = {debug_base[ADDR_W-1:2], 2'b00};
            n_d           = n_clamped;
            idx_d         = '0;
            stop_d        = stop_on_first;
            res_d         = '0;
            res_d.timeout = !start;
            if (n_clamped == '0) begin
                state_d    = StDone;
                res_d.pass = 1'b1;
            end else begin
                state_d = StReq;
            end
        end else begin
            case (state_q)
                StReq: begin
                    if (mem.req_ready) begin
                        state_d = StRsp;
                    end
                end
                StRsp: begin
                    if (mem.rsp_valid) begin
                        if (mismatch) begin
                            if (res_q.err_count == '0) begin
                                res_d.first_err_addr = cur_addr;
                                res_d.first_err_mem  = mem.rsp_data;
                                res_d.first_err_gold = mem.golden_data;
                            end
                            if (res_q.err_count != '1) begin
                                res_d.err_count = res_q.err_count + 1'b1;
                            end
                        end
                        idx_d = idx_next;
                        if (idx_next == n_q || (mismatch && stop_q)) begin
                            state_d    = StDone;
                            res_d.pass = (res_d.err_count == '0);
                        end else begin
                            state_d = StReq;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
            base_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            res_q   <= res_d;
        end
    end

    // golden_idx stays on the current index through RSP so the golden source lines up with data.
    assign mem.req_valid  = (state_q == StReq);
    assign mem.req_addr   = cur_addr;
    assign mem.golden_idx = idx_q;

    assign busy           = (state_q == StReq) || (state_q == StRsp);
    assign done           = (state_q == StDone);
    assign pass           = done && res_q.pass;
    assign timeout        = res_q.timeout;
    assign err_count      = res_q.err_count;
    assign first_err_addr = res_q.first_err_addr;
    assign first_err_mem  = res_q.first_err_mem;
    assign first_err_gold = res_q.first_err_gold;

endmodule
